// File: rtl/spi_sram_pkg.sv
// Shared constants and FSM encoding for the SPI serial-SRAM responder.
// Covers the command opcodes, the default address width and the state enum.
package spi_sram_pkg;

    localparam int SRAM_ADDR_W = 24;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } spi_state_t;

endpackage

// File: rtl/spi_sram_responder.sv
// SPI target emulating a 23LC-style serial SRAM in sequential mode; clk doubles as SCK.
// Turns READ/WRITE frames into single-cycle requests on a synchronous memory port.
module spi_sram_responder
    import spi_sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int CMD_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam int CNT_W = $clog2((ADDR_W > CMD_W) ? ADDR_W : CMD_W);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    spi_state_t        state_q;
    spi_state_t        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CMD_W-1:0]  cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        sh_q;
    logic              is_write_q;
    logic              rd_wait_q;

    logic [CMD_W-1:0]  cmd_next;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] addr_inc;
    logic [7:0]        byte_next;
    logic              cmd_done;
    logic              addr_done;
    logic              byte_done;
    logic              cmd_known;

    assign cmd_next  = {cmd_q[CMD_W-2:0], mosi};
    assign addr_next = {addr_q[ADDR_W-2:0], mosi};
    assign addr_inc  = addr_q + ADDR_W'(1);
    assign byte_next = {sh_q[6:0], mosi};
    assign cmd_done  = (cnt_q == CMD_LAST);
    assign addr_done = (cnt_q == ADDR_LAST);
    assign byte_done = (cnt_q == BYTE_LAST);
    assign cmd_known = (cmd_next == CMD_W'(CMD_WRITE)) || (cmd_next == CMD_W'(CMD_READ));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CMD;
        end else if (en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cs_n) begin
            state_d = ST_CMD;
        end else begin
            case (state_q)
                ST_CMD:  if (cmd_done)  state_d = cmd_known ? ST_ADDR : ST_IGNORE;
                ST_ADDR: if (addr_done) state_d = is_write_q ? ST_WDATA : ST_RDATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            sh_q       <= '0;
            is_write_q <= 1'b0;
            rd_wait_q  <= 1'b0;
            miso       <= 1'b0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (en) begin
            mem_en <= 1'b0;
            miso   <= 1'b0;
            if (cs_n) begin
                cnt_q     <= '0;
                rd_wait_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_CMD: begin
                        cmd_q <= cmd_next;
                        cnt_q <= cmd_done ? '0 : cnt_q + CNT_ONE;
                        if (cmd_done) is_write_q <= (cmd_next == CMD_W'(CMD_WRITE));
                    end
                    ST_ADDR: begin
                        addr_q <= addr_next;
                        cnt_q  <= addr_done ? '0 : cnt_q + CNT_ONE;
                        if (addr_done && !is_write_q) begin
                            mem_en    <= 1'b1;
                            mem_wr    <= 1'b0;
                            mem_addr  <= addr_next;
                            rd_wait_q <= 1'b1;
                        end
                    end
                    ST_WDATA: begin
                        sh_q  <= byte_next;
                        cnt_q <= byte_done ? '0 : cnt_q + CNT_ONE;
                        if (byte_done) begin
                            mem_en    <= 1'b1;
                            mem_wr    <= 1'b1;
                            mem_addr  <= addr_q;
                            mem_wdata <= byte_next;
                            addr_q    <= addr_inc;
                        end
                    end
                    ST_RDATA: begin
                        // First cycle waits for the RAM; afterwards cnt_q==0 marks a byte boundary
                        // where the fetched byte is loaded and the next address is prefetched.
                        if (rd_wait_q) begin
                            rd_wait_q <= 1'b0;
                        end else if (cnt_q == '0) begin
                            sh_q     <= mem_rdata;
                            miso     <= mem_rdata[7];
                            addr_q   <= addr_inc;
                            mem_en   <= 1'b1;
                            mem_wr   <= 1'b0;
                            mem_addr <= addr_inc;
                            cnt_q    <= CNT_ONE;
                        end else begin
                            miso  <= sh_q[6];
                            sh_q  <= {sh_q[6:0], 1'b0};
                            cnt_q <= byte_done ? '0 : cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        cnt_q <= cnt_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: directed frame table, hand-written read/reset sequences,
// then random frames checked against a frame-level model of writes, reads and the miso stream.
module tb_spi_sram_responder;
    import spi_sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cs_n = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic [23:0] mem_addr;
    logic        mem_en;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    always #5 clk = ~clk;

    spi_sram_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .mem_addr  (mem_addr),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  ram [logic [23:0]];
    logic [7:0]  model_mem [logic [23:0]];
    logic [31:0] wr_log[$];
    logic [23:0] rd_log[$];
    logic        miso_q[$];
    logic [31:0] exp_q[$];
    logic [23:0] exp_rd_q[$];

    typedef struct {
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          n_data;
        logic [31:0] data;
        int          stall_at;
        int          exp_n;
        logic [23:0] exp_a0;
        logic [7:0]  exp_d0;
        logic [23:0] exp_a1;
        logic [7:0]  exp_d1;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [7:0] fill_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] model_byte(input logic [23:0] a);
        return model_mem.exists(a) ? model_mem[a] : fill_byte(a);
    endfunction

    // Synchronous RAM on the memory port; it only sees requests on enabled edges.
    always @(posedge clk) begin
        if (en && mem_en) begin
            if (mem_wr) begin
                ram[mem_addr] = mem_wdata;
                wr_log.push_back({mem_addr, mem_wdata});
            end else begin
                mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : fill_byte(mem_addr);
                rd_log.push_back(mem_addr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drives n bits of fv (MSB first) inside one cs_n-low frame, then two idle edges.
    task automatic run_frame(input logic [95:0] fv, input int n, input int stall_at,
                             input int stall_len);
        logic last;
        miso_q.delete();
        wr_log.delete();
        rd_log.delete();
        last = miso;
        for (int k = 0; k < n; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    cs_n = 1'b0; en = 1'b0; mosi = 1'($urandom);
                    @(posedge clk); #1;
                    check("stall_hold_miso", 32'(miso), 32'(last));
                end
            end
            @(negedge clk);
            cs_n = 1'b0; en = 1'b1; mosi = fv[95-k];
            @(posedge clk); #1;
            miso_q.push_back(miso);
            last = miso;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cs_n = 1'b1; en = 1'b1; mosi = 1'($urandom);
            @(posedge clk); #1;
            check("idle_miso", 32'(miso), 32'd0);
        end
    endtask

    // Frame-level reference: writes land at addr+i, reads prefetch one byte per 8 clocks,
    // and miso carries memory bytes MSB first starting 2 edges after the last address bit.
    task automatic check_model(input logic [95:0] fv, input int n);
        logic [7:0]  cmd;
        logic [23:0] a0;
        logic [63:0] d;
        logic [23:0] a;
        logic [7:0]  bval;
        logic        expb;
        int          j;
        cmd = fv[95:88];
        a0  = fv[87:64];
        d   = fv[63:0];
        exp_q.delete();
        exp_rd_q.delete();
        if (n >= 32 && cmd == CMD_WRITE) begin
            for (int i = 0; i < (n - 32) / 8; i++) begin
                a    = a0 + 24'(i);
                bval = d[63-8*i -: 8];
                exp_q.push_back({a, bval});
                model_mem[a] = bval;
            end
        end
        if (n >= 32 && cmd == CMD_READ) begin
            exp_rd_q.push_back(a0);
            for (int m = 0; 33 + 8 * m <= n - 1; m++) exp_rd_q.push_back(a0 + 24'(m + 1));
        end
        check("wr_count", 32'(wr_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < wr_log.size() && i < exp_q.size(); i++)
            check("wr_entry", wr_log[i], exp_q[i]);
        check("rd_count", 32'(rd_log.size()), 32'(exp_rd_q.size()));
        for (int i = 0; i < rd_log.size() && i < exp_rd_q.size(); i++)
            check("rd_addr", 32'(rd_log[i]), 32'(exp_rd_q[i]));
        check("miso_count", 32'(miso_q.size()), 32'(n));
        for (int k = 0; k < n && k < miso_q.size(); k++) begin
            expb = 1'b0;
            if (cmd == CMD_READ && n >= 32 && k >= 33) begin
                j    = k - 33;
                bval = model_byte(a0 + 24'(j / 8));
                expb = bval[7 - (j % 8)];
            end
            check("miso_bit", 32'(miso_q[k]), 32'(expb));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [95:0] fv;
        logic [15:0] stream;
        logic        any_miso;
        logic [31:0] got;
        int          n;
        int          kind;
        int          stall_at;
        logic [7:0]  cmd;
        logic [23:0] addr;

        tbl[0] = '{8'h02, 24'h000200,  8, 32'hA5000000, -1, 1, 24'h000200, 8'hA5, 24'h000000, 8'h00};
        tbl[1] = '{8'h02, 24'h000200, 16, 32'h11220000, -1, 2, 24'h000200, 8'h11, 24'h000201, 8'h22};
        tbl[2] = '{8'h02, 24'h000010,  5, 32'hF8000000, -1, 0, 24'h000000, 8'h00, 24'h000000, 8'h00};
        tbl[3] = '{8'h02, 24'hFFFFFF, 16, 32'hC33C0000, -1, 2, 24'hFFFFFF, 8'hC3, 24'h000000, 8'h3C};
        tbl[4] = '{8'h05, 24'h000200, 16, 32'hFFFF0000, -1, 0, 24'h000000, 8'h00, 24'h000000, 8'h00};
        tbl[5] = '{8'h02, 24'h000300,  8, 32'h96000000, 35, 1, 24'h000300, 8'h96, 24'h000000, 8'h00};

        // Reset held with an active-looking bus.
        rst_n = 1'b0; cs_n = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mosi = ~mosi;
            @(posedge clk); #1;
            check("rst_miso", 32'(miso), 32'd0);
            check("rst_mem_en", 32'(mem_en), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
        end
        @(negedge clk); rst_n = 1'b1; cs_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            fv = {tbl[t].cmd, tbl[t].addr, tbl[t].data, 32'h0};
            run_frame(fv, 32 + tbl[t].n_data, tbl[t].stall_at, 3);
            check("tbl_wr_count", 32'(wr_log.size()), 32'(tbl[t].exp_n));
            if (tbl[t].exp_n >= 1) begin
                got = (wr_log.size() > 0) ? wr_log[0] : 32'hDEADBEEF;
                check("tbl_wr0", got, {tbl[t].exp_a0, tbl[t].exp_d0});
                model_mem[tbl[t].exp_a0] = tbl[t].exp_d0;
            end
            if (tbl[t].exp_n >= 2) begin
                got = (wr_log.size() > 1) ? wr_log[1] : 32'hDEADBEEF;
                check("tbl_wr1", got, {tbl[t].exp_a1, tbl[t].exp_d1});
                model_mem[tbl[t].exp_a1] = tbl[t].exp_d1;
            end
            check("tbl_rd_count", 32'(rd_log.size()), 32'd0);
            any_miso = 1'b0;
            foreach (miso_q[k]) any_miso |= miso_q[k];
            check("tbl_miso_zero", 32'(any_miso), 32'd0);
        end

        // Read with prefetch: 0x00 then 0x04 stream out with no gap.
        ram[24'h00FFFC] = 8'h00; model_mem[24'h00FFFC] = 8'h00;
        ram[24'h00FFFD] = 8'h04; model_mem[24'h00FFFD] = 8'h04;
        fv = {8'h03, 24'h00FFFC, 64'h0};
        run_frame(fv, 49, -1, 0);
        check("rd_strobes", 32'(rd_log.size()), 32'd3);
        check("rd_addr0", (rd_log.size() > 0) ? 32'(rd_log[0]) : 32'hDEADBEEF, 32'h00FFFC);
        check("rd_addr1", (rd_log.size() > 1) ? 32'(rd_log[1]) : 32'hDEADBEEF, 32'h00FFFD);
        check("rd_miso_len", 32'(miso_q.size()), 32'd49);
        any_miso = 1'b0;
        for (int k = 0; k < 33 && k < miso_q.size(); k++) any_miso |= miso_q[k];
        check("rd_latency_zero", 32'(any_miso), 32'd0);
        stream = '0;
        for (int k = 33; k < 49 && k < miso_q.size(); k++) stream = {stream[14:0], miso_q[k]};
        check("rd_stream", 32'(stream), 32'h0004);

        // Asynchronous reset in the middle of a write frame.
        wr_log.delete();
        fv = {8'h02, 24'h000400, 64'hFFFF_FFFF_FFFF_FFFF};
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); cs_n = 1'b0; en = 1'b1; mosi = fv[95-k];
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("arst_mem_addr", 32'(mem_addr), 32'd0);
        check("arst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("arst_mem_en", 32'(mem_en), 32'd0);
        check("arst_mem_wr", 32'(mem_wr), 32'd0);
        check("arst_miso", 32'(miso), 32'd0);
        @(negedge clk); cs_n = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        check("arst_no_write", 32'(wr_log.size()), 32'd0);

        // Random frames against the frame-level model.
        for (int r = 0; r < 80; r++) begin
            kind = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0, 1:    addr = 24'($urandom);
                2:       addr = 24'hFFFFF0 + 24'($urandom_range(0, 15));
                default: addr = 24'($urandom_range(0, 255));
            endcase
            if (kind <= 3) begin
                cmd = CMD_WRITE;
                n   = 32 + 8 * $urandom_range(0, 4) + $urandom_range(0, 7);
            end else if (kind <= 7) begin
                cmd = CMD_READ;
                n   = 32 + $urandom_range(0, 40);
            end else if (kind == 8) begin
                do cmd = 8'($urandom); while (cmd == CMD_WRITE || cmd == CMD_READ);
                n = 8 + $urandom_range(0, 30);
            end else begin
                cmd = ($urandom_range(0, 1) == 0) ? CMD_WRITE : CMD_READ;
                n   = $urandom_range(1, 31);
            end
            fv = {cmd, addr, 32'($urandom), 32'($urandom)};
            stall_at = ($urandom_range(0, 9) < 3) ? $urandom_range(0, n - 1) : -1;
            run_frame(fv, n, stall_at, $urandom_range(1, 3));
            check_model(fv, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
